// File: rtl/cmd_led_pkg.sv
// ============================================================================
// cmd_led_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the badge command decoder / LED driver.
//   - Command byte values and the argument base used to form channel indices
//   - Response bytes returned when the command echo path is built in
//     (CMD_ECHO_EN)
//   - Decoder FSM state encoding
//   - Saturating byte increment used by the error counter
// ============================================================================
package cmd_led_pkg;

    localparam logic [7:0] CMD_KILL = 8'd65;   // 'A'
    localparam logic [7:0] CMD_SET  = 8'd83;   // 'S'
    localparam logic [7:0] CMD_DUTY = 8'd68;   // 'D'
    localparam logic [7:0] ARG_ALL  = 8'd96;   // 0x60 : every channel
    localparam logic [7:0] ARG_BASE = 8'd65;   // 'A' : channel 0

    localparam logic [7:0] RSP_ACK  = 8'd75;   // 'K'
    localparam logic [7:0] RSP_NAK  = 8'd78;   // 'N'

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_END  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Counter that sticks at 255 instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_led_ctrl_pwm_gen.sv
// ============================================================================
// pwm_gen
// ----------------------------------------------------------------------------
// Free-running PWM_BITS counter with a registered duty compare.
// Ports:
//   i_clk     - clock
//   i_reset   - asynchronous active-high reset
//   i_duty    - duty value; output is high while counter < duty
//   o_pwm_on  - registered compare result
// ============================================================================
module pwm_gen #(
    parameter int PWM_BITS = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_on
);

    logic [PWM_BITS-1:0] r_cnt;
    logic                r_pwm_on;

    // Counter wraps naturally at all-ones. The compare is registered so the
    // LED path only sees a flop output, never the comparator carry chain;
    // duty 0 can never be on and all-ones is on for all but one count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_pwm_on <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + PWM_BITS'(1);
            r_pwm_on <= (r_cnt < i_duty);
        end
    end

    assign o_pwm_on = r_pwm_on;

endmodule

// File: rtl/cmd_led_ctrl.sv
// ============================================================================
// cmd_led_ctrl
// ----------------------------------------------------------------------------
// Decodes framed 3-byte commands (CMD, ARG, END==CMD) from the UART receive
// path, keeps a per-channel status mask and a global PWM duty, and drives
// N_CH LEDs from the status mask and an external challenge pattern.
//
// Optional feature macro: CMD_ECHO_EN
//   defined   : each completed frame is answered with 'K' / 'N' on the tx
//               handshake; the decoder stalls in RESP until it is taken.
//   undefined : tx_valid / tx_data are tied low and i_tx_ready is ignored.
//
// Ports:
//   i_clk, i_reset           - clock, asynchronous active-high reset
//   i_rx_data/valid, o_rx_ready - byte input handshake
//   i_base_pattern           - challenge LED pattern, gated by PWM
//   o_led                    - LED drive
//   o_status                 - status mask, 1 = alive
//   o_frame_ok / o_frame_err - one-cycle pulses per accepted / bad frame
//   o_err_count              - saturating error counter
//   o_tx_data/valid, i_tx_ready - response byte handshake
// ============================================================================
module cmd_led_ctrl
    import cmd_led_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int PWM_BITS    = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_valid,
    output logic            o_rx_ready,
    input  logic [N_CH-1:0] i_base_pattern,
    output logic [N_CH-1:0] o_led,
    output logic [N_CH-1:0] o_status,
    output logic            o_frame_ok,
    output logic            o_frame_err,
    output logic [7:0]      o_err_count,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready
);

    localparam int                  TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [PWM_BITS-1:0] DUTY_RST = PWM_BITS'(1) << (PWM_BITS - 1);

    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [7:0]          r_arg;
    logic [N_CH-1:0]     r_status;
    logic [PWM_BITS-1:0] r_duty;
    logic [7:0]          r_err_count;
    logic                r_frame_ok;
    logic                r_frame_err;
    logic [TMR_W-1:0]    r_timer;
`ifdef CMD_ECHO_EN
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
`endif

    logic                w_rx_ready;
    logic                w_accept;
    logic [7:0]          w_idx;
    logic                w_idx_ok;
    logic [N_CH-1:0]     w_onehot;
    logic                w_cmd_ok;
    logic                w_frame_good;
    logic                w_timeout;
    logic                w_pwm_on;

    assign w_rx_ready = (r_state != ST_RESP);
    assign w_accept   = i_rx_valid & w_rx_ready;

    // ARG below 'A' wraps to a large index, so the >= check is what rejects
    // negative channel numbers.
    assign w_idx      = r_arg - ARG_BASE;
    assign w_idx_ok   = (r_arg >= ARG_BASE) && (32'(w_idx) < N_CH);
    assign w_onehot   = N_CH'(1) << w_idx;

    // Whether the latched CMD/ARG pair is executable; END is checked
    // separately against the byte arriving now.
    always_comb begin
        w_cmd_ok = 1'b0;
        case (r_cmd)
            CMD_KILL: w_cmd_ok = (r_arg == ARG_ALL) || w_idx_ok;
            CMD_SET:  w_cmd_ok = w_idx_ok;
            CMD_DUTY: w_cmd_ok = 1'b1;
            default:  w_cmd_ok = 1'b0;
        endcase
    end

    assign w_frame_good = w_cmd_ok && (i_rx_data == r_cmd);

    // A byte accepted on the expiring cycle wins over the abort.
    assign w_timeout = ((r_state == ST_ARG) || (r_state == ST_END)) &&
                       !w_accept && (r_timer == TMR_LAST);

    // Decoder FSM plus all architectural state. Status, duty and the result
    // pulses change on the edge that accepts END so they are visible in the
    // very next cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 8'd0;
            r_arg       <= 8'd0;
            r_status    <= '1;
            r_duty      <= DUTY_RST;
            r_err_count <= 8'd0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_timer     <= '0;
`ifdef CMD_ECHO_EN
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
`endif
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= i_rx_data;
                        r_timer <= '0;
                        r_state <= ST_ARG;
                    end
                end
                ST_ARG: begin
                    if (w_accept) begin
                        r_arg   <= i_rx_data;
                        r_timer <= '0;
                        r_state <= ST_END;
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_err_count <= sat_inc8(r_err_count);
                        r_timer     <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_END: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (w_frame_good) begin
                            r_frame_ok <= 1'b1;
                            case (r_cmd)
                                CMD_KILL: begin
                                    if (r_arg == ARG_ALL) r_status <= '1;
                                    else                  r_status <= r_status & ~w_onehot;
                                end
                                CMD_SET:  r_status <= r_status | w_onehot;
                                CMD_DUTY: r_duty   <= r_arg[PWM_BITS-1:0];
                                default:  r_status <= r_status;
                            endcase
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_count <= sat_inc8(r_err_count);
                        end
`ifdef CMD_ECHO_EN
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_frame_good ? RSP_ACK : RSP_NAK;
                        r_state    <= ST_RESP;
`else
                        r_state    <= ST_IDLE;
`endif
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_err_count <= sat_inc8(r_err_count);
                        r_timer     <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_RESP: begin
`ifdef CMD_ECHO_EN
                    if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_duty   (r_duty),
        .o_pwm_on (w_pwm_on)
    );

    // A dead channel (status 0) is lit solid regardless of the pattern.
    assign o_led       = (i_base_pattern & {N_CH{w_pwm_on}}) | ~r_status;
    assign o_rx_ready  = w_rx_ready;
    assign o_status    = r_status;
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_err = r_frame_err;
    assign o_err_count = r_err_count;

`ifdef CMD_ECHO_EN
    assign o_tx_valid  = r_tx_valid;
    assign o_tx_data   = r_tx_data;
`else
    logic w_unused_tx_ready;
    assign w_unused_tx_ready = i_tx_ready;
    assign o_tx_valid  = 1'b0;
    assign o_tx_data   = 8'd0;
`endif

endmodule

// File: tb/tb_cmd_led_ctrl.sv
// ============================================================================
// tb_cmd_led_ctrl
// ----------------------------------------------------------------------------
// Directed frames with hand-computed expected status / error count. Each
// issued frame pushes its expectation into a queue; monitors pop and compare
// whenever the DUT pulses frame_ok / frame_err (and, with CMD_ECHO_EN, when a
// response byte is handshaked).
// ============================================================================
module tb_cmd_led_ctrl;

    localparam int N_CH        = 8;
    localparam int PWM_BITS    = 4;
    localparam int TIMEOUT_CYC = 20;

    logic            clk         = 1'b0;
    logic            reset       = 1'b1;
    logic [7:0]      rxData      = 8'h00;
    logic            rxValid     = 1'b0;
    logic            rxReady;
    logic [N_CH-1:0] basePattern = '0;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] status;
    logic            frameOk;
    logic            frameErr;
    logic [7:0]      errCount;
    logic [7:0]      txData;
    logic            txValid;
    logic            txReady     = 1'b1;

    typedef struct {
        bit         isOk;
        logic [7:0] status;
        logic [7:0] errCount;
    } expFrame_t;

    expFrame_t  frameQ[$];
    logic [7:0] respQ[$];
    expFrame_t  monEntry;
    logic [7:0] monResp;
    int         compared   = 0;
    int         mismatched = 0;

    cmd_led_ctrl #(
        .N_CH        (N_CH),
        .PWM_BITS    (PWM_BITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_data      (rxData),
        .i_rx_valid     (rxValid),
        .o_rx_ready     (rxReady),
        .i_base_pattern (basePattern),
        .o_led          (led),
        .o_status       (status),
        .o_frame_ok     (frameOk),
        .o_frame_err    (frameErr),
        .o_err_count    (errCount),
        .o_tx_data      (txData),
        .o_tx_valid     (txValid),
        .i_tx_ready     (txReady)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect(input bit isOk, input logic [7:0] expStatus, input logic [7:0] expErr, input bit withResp);
        expFrame_t x;
        x.isOk     = isOk;
        x.status   = expStatus;
        x.errCount = expErr;
        frameQ.push_back(x);
`ifdef CMD_ECHO_EN
        if (withResp) respQ.push_back(isOk ? 8'd75 : 8'd78);
`else
        if (withResp) respQ.delete();
`endif
    endtask

    // Presents a byte from the negedge and returns just after the edge that
    // accepts it; rx_ready is only looked at on negedges where it is stable.
    task automatic sendByte(input logic [7:0] b);
        int waitCnt = 0;
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!rxReady) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL rx_ready_wait: got rx_ready=0 for 100 cycles required 1");
        end
        @(posedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic [7:0] a, input logic [7:0] e,
                                 input bit expOk, input logic [7:0] expStatus, input logic [7:0] expErr,
                                 input bit holdValid);
        pushExpect(expOk, expStatus, expErr, 1'b1);
        sendByte(c);
        sendByte(a);
        sendByte(e);
        if (!holdValid) begin
            @(negedge clk);
            rxValid = 1'b0;
        end
    endtask

    task automatic countLed(input int cycles, output int onCnt, output int badCnt);
        onCnt  = 0;
        badCnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (led == 8'hFF)      onCnt++;
            else if (led != 8'h00) badCnt++;
        end
    endtask

    // Scoreboard monitor for command results.
    always @(negedge clk) begin
        if (!reset && (frameOk || frameErr)) begin
            if (frameQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: got ok=%0b err=%0b required no pulse", frameOk, frameErr);
            end else begin
                monEntry = frameQ.pop_front();
                checkOutput("frame_kind", {30'd0, frameOk, frameErr}, monEntry.isOk ? 32'd2 : 32'd1);
                checkOutput("frame_status", status, monEntry.status);
                checkOutput("frame_err_count", errCount, monEntry.errCount);
            end
        end
    end

`ifdef CMD_ECHO_EN
    // Scoreboard monitor for response bytes.
    always @(negedge clk) begin
        if (!reset && txValid && txReady) begin
            if (respQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_resp: got 0x%0h required no response", txData);
            end else begin
                monResp = respQ.pop_front();
                checkOutput("tx_data", txData, monResp);
            end
        end
    end
`endif

    initial begin
        int onCnt;
        int badCnt;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_status", status, 8'hFF);
        checkOutput("reset_led", led, 8'h00);
        checkOutput("reset_err_count", errCount, 0);
        checkOutput("reset_frame_pulses", {frameOk, frameErr}, 0);
        checkOutput("reset_tx_valid", txValid, 0);
        checkOutput("reset_tx_data", txData, 0);
        checkOutput("reset_rx_ready", rxReady, 1);

        // Reset duty is half scale: 16 of 32 cycles lit.
        basePattern = 8'hFF;
        countLed(32, onCnt, badCnt);
        checkOutput("pwm_reset_duty_on", onCnt, 16);
        checkOutput("pwm_reset_duty_bad", badCnt, 0);
        basePattern = 8'h00;

        applyStimulus("A", "C", "A", 1'b1, 8'hFB, 8'd0, 1'b0);
        checkOutput("led_dead_ch2", led, 8'h04);
        applyStimulus("A", 8'h60, "A", 1'b1, 8'hFF, 8'd0, 1'b0);
        checkOutput("led_all_alive", led, 8'h00);

        applyStimulus("A", "C", "B", 1'b0, 8'hFF, 8'd1, 1'b0);
        applyStimulus("A", "I", "A", 1'b0, 8'hFF, 8'd2, 1'b0);
        applyStimulus("Q", "A", "Q", 1'b0, 8'hFF, 8'd3, 1'b0);
        applyStimulus("S", "@", "S", 1'b0, 8'hFF, 8'd4, 1'b0);
        applyStimulus("A", "H", "A", 1'b1, 8'h7F, 8'd4, 1'b0);
        applyStimulus("S", "H", "S", 1'b1, 8'hFF, 8'd4, 1'b0);

        applyStimulus("A", "A", "A", 1'b1, 8'hFE, 8'd4, 1'b1);
        applyStimulus("S", "A", "S", 1'b1, 8'hFF, 8'd4, 1'b0);

        applyStimulus("D", 8'h03, "D", 1'b1, 8'hFF, 8'd4, 1'b0);
        basePattern = 8'hFF;
        repeat (3) @(negedge clk);
        countLed(32, onCnt, badCnt);
        checkOutput("pwm_duty3_on", onCnt, 6);
        checkOutput("pwm_duty3_bad", badCnt, 0);

        applyStimulus("D", 8'h4F, "D", 1'b1, 8'hFF, 8'd4, 1'b0);
        repeat (3) @(negedge clk);
        countLed(32, onCnt, badCnt);
        checkOutput("pwm_duty15_on", onCnt, 30);
        checkOutput("pwm_duty15_bad", badCnt, 0);

        applyStimulus("D", 8'h00, "D", 1'b1, 8'hFF, 8'd4, 1'b0);
        repeat (3) @(negedge clk);
        countLed(32, onCnt, badCnt);
        checkOutput("pwm_duty0_on", onCnt, 0);
        checkOutput("pwm_duty0_bad", badCnt, 0);
        basePattern = 8'h00;

        // Full stall after CMD: abort exactly TIMEOUT_CYC idle cycles later.
        pushExpect(1'b0, 8'hFF, 8'd5, 1'b0);
        sendByte("A");
        @(negedge clk);
        rxValid = 1'b0;
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        checkOutput("timeout_not_early", frameErr, 0);
        @(negedge clk);
        checkOutput("timeout_pulse", frameErr, 1);
        applyStimulus("S", "A", "S", 1'b1, 8'hFF, 8'd5, 1'b0);

        // Byte arriving on the last idle cycle beats the timeout.
        pushExpect(1'b1, 8'hFD, 8'd5, 1'b1);
        sendByte("A");
        @(negedge clk);
        rxValid = 1'b0;
        repeat (TIMEOUT_CYC - 2) @(negedge clk);
        sendByte("B");
        sendByte("A");
        @(negedge clk);
        rxValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("near_timeout_drained", frameQ.size(), 0);

        // Error counter saturates at 255.
        for (int i = 1; i <= 253; i++) begin
            applyStimulus("Q", "A", "Q", 1'b0, 8'hFD, (5 + i > 255) ? 8'd255 : 8'(5 + i), 1'b0);
        end
        @(negedge clk);
        checkOutput("err_saturated", errCount, 255);

        // Asynchronous reset mid-frame discards the partial frame.
        sendByte("A");
        sendByte("C");
        @(negedge clk);
        rxValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_status", status, 8'hFF);
        checkOutput("async_reset_err_count", errCount, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("A", "D", "A", 1'b1, 8'hF7, 8'd0, 1'b0);
        checkOutput("post_reset_led", led, 8'h08);

`ifdef CMD_ECHO_EN
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 txReady = 1'b0;
        applyStimulus("A", 8'h60, "A", 1'b1, 8'hFF, 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("resp_hold_valid", txValid, 1);
            checkOutput("resp_hold_data", txData, 75);
            checkOutput("resp_hold_rx_ready", rxReady, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 txReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resp_done_valid", txValid, 0);
        checkOutput("resp_done_rx_ready", rxReady, 1);

        applyStimulus("A", "C", "B", 1'b0, 8'hFF, 8'd1, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 txReady = 1'b0;
        applyStimulus("S", "A", "S", 1'b1, 8'hFF, 8'd1, 1'b0);
        checkOutput("resp_before_reset", txValid, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("resp_reset_valid", txValid, 0);
        checkOutput("resp_reset_rx_ready", rxReady, 1);
        respQ.delete();
        @(negedge clk);
        reset   = 1'b0;
        txReady = 1'b1;
`else
        applyStimulus("A", 8'h60, "A", 1'b1, 8'hFF, 8'd0, 1'b0);
        checkOutput("no_echo_tx_valid", txValid, 0);
        checkOutput("no_echo_tx_data", txData, 0);
        checkOutput("no_echo_rx_ready", rxReady, 1);
`endif

        repeat (4) @(negedge clk);
        checkOutput("frame_queue_empty", frameQ.size(), 0);
        checkOutput("resp_queue_empty", respQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cmd_led_ctrl.md
# cmd_led_ctrl

Byte-stream command decoder and multi-channel PWM LED driver for the badge top level. It accepts framed 3-byte commands from the UART receive path and maintains a per-channel "cat status" mask and a global PWM duty. It drives `N_CH` LED outputs by combining the status mask with an externally supplied challenge pattern. It replaces the fixed 8-LED, single-command decode and hard-wired 1-in-5 PWM with a parametrised, validated, handshaked engine.

## Interface
- `N_CH`, 8, number of LED/status channels (1..26)
- `PWM_BITS`, 4, PWM counter and duty width
- `TIMEOUT_CYC`, 1_000_000, idle cycles mid-frame before abort (≥2)
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high
- `rx_data` in 8: received byte
- `rx_valid` in 1: `rx_data` valid
- `rx_ready` out 1: byte accepted when `rx_valid & rx_ready`
- `base_pattern` in `N_CH`: challenge LED pattern, gated by PWM
- `led` out `N_CH`: LED drive
- `status` out `N_CH`: status mask, 1 = alive
- `frame_ok` out 1: one-cycle pulse per accepted command
- `frame_err` out 1: one-cycle pulse per rejected or aborted frame
- `err_count` out 8: saturating error counter
- `tx_data` out 8: response byte
- `tx_valid` out 1: response valid
- `tx_ready` in 1: response consumer ready

## Operation
- Frame format: CMD, ARG, END. END must equal CMD.
- FSM states:
  - IDLE: a byte moves to ARG and latches CMD.
  - ARG: a byte latches ARG and moves to END.
  - END: a byte triggers execute/reject and returns to IDLE.
  - RESP: present only with echo; waits for `tx_ready`.
- Commands:
  - 'A' (65): ARG = 96 sets every `status` bit to 1. Otherwise ARG−65 is the channel index and that bit is cleared.
  - 'S' (83): sets bit ARG−65.
  - 'D' (68): duty ← ARG[PWM_BITS-1:0].
- Reject conditions: END ≠ CMD, unknown CMD, or channel index <0 or ≥`N_CH`. A rejected frame changes no state, pulses `frame_err`, and increments `err_count`. `err_count` saturates at 255.
- Timeout: in ARG or END, `TIMEOUT_CYC` consecutive cycles without an accepted byte return the FSM to IDLE, pulse `frame_err`, and increment `err_count`. The timer restarts on every accepted byte.
- PWM: free-running `PWM_BITS` counter that wraps at all-ones. `pwm_on = cnt < duty`, so duty 0 is always off and duty all-ones is on (2^PWM_BITS−1)/2^PWM_BITS of the time.
- `led[i] = (base_pattern[i] & pwm_on) | ~status[i]`.
- Reset values:
  - FSM = IDLE
  - `status` all 1
  - duty = 2^(PWM_BITS−1)
  - `err_count` 0
  - cnt 0
  - `frame_ok`, `frame_err`, `tx_valid` all 0
  - `tx_data` 0
- `rx_ready` = 1 except in RESP.

## Timing
- Execute latency: `status`, duty, `frame_ok` and `frame_err` update on the clock edge that accepts END. They are visible in the following cycle.
- `led` is combinational from registered `status`, the registered PWM compare, and `base_pattern`.
- Bytes may arrive back-to-back, one per cycle, with no gaps required.
- A timeout and an accepted byte in the same cycle: the byte wins and there is no error.
- `reset` mid-frame discards the partial frame immediately, without a clock.

## Configuration
- `CMD_ECHO_EN` defined:
  - After END, the FSM enters RESP with `tx_valid` = 1.
  - `tx_data` is 'K' (75) for success or 'N' (78) for reject.
  - The FSM holds until `tx_valid & tx_ready`, then returns to IDLE.
  - Timeout aborts do not enter RESP.
  - `rx_ready` = 0 while in RESP.
- `CMD_ECHO_EN` undefined: RESP is unreachable, `tx_valid` is tied 0, `tx_data` is tied 0, and `tx_ready` is ignored.

## Structure
- Package `cmd_led_pkg`:
  - command byte constants (CMD_KILL 65, CMD_SET 83, CMD_DUTY 68, ARG_ALL 96, ARG_BASE 65)
  - response constants (ACK 75, NAK 78)
  - FSM state enum
- Sub-module `pwm_gen`, parametrised by `PWM_BITS`: counter plus registered compare, outputs `pwm_on`.

## Test plan
- Reset, then idle with `base_pattern` = 0: `status` = all 1s, `led` = 0, `err_count` = 0.
- Send 'A','C','A': bit 2 cleared, `led[2]` = 1, one `frame_ok` pulse. Then send 'A','`','A': `status` = all 1s.
- Send 'A','C','B': `frame_err` pulse, `status` unchanged, `err_count` = 1. Send 'A','I','A' with `N_CH` = 8: rejected, `err_count` = 2.
- Send 'D',0x03,'D' with `PWM_BITS` = 4 and `base_pattern` = 0xFF: `led` high for 3 of every 16 cycles. Duty 0: `led` always 0.
- Send 'A' then stall `TIMEOUT_CYC` cycles: `frame_err` pulse, FSM IDLE. A following 'S','A','S' is accepted.
- With `CMD_ECHO_EN` and `tx_ready` held low 10 cycles after a valid frame: `tx_valid` = 1, `tx_data` = 75, `rx_ready` = 0 until the handshake completes. Assert `reset` during RESP: `tx_valid` = 0 immediately.
